decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for the ID/EX register and register-file writes.
REQ-003 reset  input  1  asynchronous, active-low; clears the register file and the ID/EX register.
REQ-004 RegWriteW  input  1  writeback write enable.
REQ-005 InstrD  input  20  instruction in decode.
REQ-006 ResultW  input  19  writeback data.
REQ-007 PCD  input  15  PC of the decode instruction.
REQ-008 RdW  input  5  writeback destination register.
REQ-009 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered control bits.
REQ-010 ResultSrcE  output  2  result select: 00 ALU, 01 memory, 10 PC+1.
REQ-011 ALUControlE  output  3  ALU operation.
REQ-012 RD1E, RD2E, ImmExtE  output  19 each  source operands and extended immediate.
REQ-013 PCE  output  15  registered PCD.
REQ-014 RDE  output  5  registered destination (InstrD[9:5]).

Function
REQ-015 Fields SHALL be: type = InstrD[4:3], funct = InstrD[2:0], rd = InstrD[9:5], rs1 = InstrD[14:10], rs2 = InstrD[19:15].
REQ-016 Register file SHALL hold 19 registers r0..r18 of 19 bits; r0 reads 0 and ignores writes; addresses 19..31 read 0 and ignore writes.
REQ-017 Port 1 address SHALL be rs1; port 2 address SHALL be rs2 for type 00, else InstrD[9:5].
REQ-018 Reads SHALL be combinational; a write of ResultW to RdW SHALL occur on the rising clk edge when RegWriteW=1.
REQ-019 Type 00 (R-ALU): RegWrite=1, ALUSrc=0, ResultSrc=00, ALUControl=funct.
REQ-020 Type 01, funct 000..110 (I-ALU): RegWrite=1, ALUSrc=1, ResultSrc=00, ALUControl=funct.
REQ-021 Type 01, funct 111 (load): RegWrite=1, ALUSrc=1, ResultSrc=01, ALUControl=000.
REQ-022 Type 10, funct 000 (store): MemWrite=1, ALUSrc=1, ALUControl=000, RegWrite=0.
REQ-023 Type 10, funct 001 (branch-equal): Branch=1, ALUSrc=0, ALUControl=001, RegWrite=0.
REQ-024 Type 10, funct 010..111: all controls 0 (NOP).
REQ-025 Type 11 (jump-and-link): Jump=1, RegWrite=1, ResultSrc=10, ALUSrc=0, ALUControl=000.
REQ-026 Immediate: types 00/01/10 sign-extend InstrD[19:15] to 19 bits; type 11 sign-extends InstrD[19:10] to 19 bits.
REQ-027 All outputs SHALL be registered in one ID/EX register updated every rising clk edge; latency 1 cycle; no stall or flush.

Reset
REQ-028 While reset=0 every output SHALL be 0 and all registers r1..r18 SHALL be 0, asynchronously, including mid-cycle.
REQ-029 No register-file write SHALL occur while reset=0; the first capture SHALL be at the first rising edge with reset=1.

Configuration
REQ-030 With DECODE_BYPASS_EN defined, a read whose address equals RdW (nonzero, <19) with RegWriteW=1 SHALL return ResultW in the same cycle.
REQ-031 Without DECODE_BYPASS_EN, such a read SHALL return the old register value; the new value appears the following cycle.

Verification
REQ-032 reset=0 mid-cycle after activity -> all outputs 0 immediately, register file cleared.
REQ-033 reset=1, InstrD=0x00429, PCD=0x5, RegWriteW=0, one edge -> RegWriteE=1, ALUSrcE=1, ALUControlE=001, ResultSrcE=00, RD1E=0, ImmExtE=0, PCE=0x5, RDE=1, MemWriteE=JumpE=BranchE=0.
REQ-034 RegWriteW=1, RdW=5, ResultW=0x5, InstrD=0x01440 -> RD1E=0x5 after that edge with DECODE_BYPASS_EN, else 0 then 0x5 one edge later; RDE=2.
REQ-035 RegWriteW=1, RdW=0, ResultW=0x7 then read r0 -> RD1E=0; RdW=20 write -> no register changes.
REQ-036 InstrD=0xF8008 (I-ALU, imm 11111) -> ImmExtE=0x7FFFF; InstrD=0x80018 (jump) -> JumpE=1, RegWriteE=1, ResultSrcE=10, ImmExtE=0x7FE00.
REQ-037 InstrD=0x00010 (store) -> MemWriteE=1, RegWriteE=0; InstrD=0x00011 (branch) -> BranchE=1, ALUControlE=001.

Source files
------------

// File: rtl/decode.sv
// Decode stage: instruction field split, 19x19 register file, control decode and ID/EX register.
// Optional macro DECODE_BYPASS_EN forwards a same-cycle writeback to the register read ports.
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteW,
    input  logic [19:0] InstrD,
    input  logic [18:0] ResultW,
    input  logic [14:0] PCD,
    input  logic [4:0]  RdW,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [18:0] RD1E,
    output logic [18:0] RD2E,
    output logic [18:0] ImmExtE,
    output logic [14:0] PCE,
    output logic [4:0]  RDE
);

    typedef enum logic [1:0] {
        T_RALU = 2'b00,
        T_IALU = 2'b01,
        T_MEM  = 2'b10,
        T_JAL  = 2'b11
    } instr_type_t;

    instr_type_t w_type;
    logic [2:0]  w_funct;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_a2;
    logic        w_wr_en;
    logic [18:0] w_rd1, w_rd2, w_imm;
    logic        w_regwrite, w_memwrite, w_jump, w_branch, w_alusrc;
    logic [1:0]  w_resultsrc;
    logic [2:0]  w_aluctrl;

    logic [18:0] r_regs [1:18];

    assign w_type  = instr_type_t'(InstrD[4:3]);
    assign w_funct = InstrD[2:0];
    assign w_rd    = InstrD[9:5];
    assign w_rs1   = InstrD[14:10];
    assign w_rs2   = InstrD[19:15];
    assign w_a2    = (w_type == T_RALU) ? w_rs2 : w_rd;
    assign w_wr_en = RegWriteW && (RdW != 5'd0) && (RdW < 5'd19);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i <= 18; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[RdW] <= ResultW;
        end
    end

    // r0 and addresses 19..31 are hardwired to zero
    always_comb begin
        w_rd1 = '0;
        if (w_rs1 != 5'd0 && w_rs1 < 5'd19) w_rd1 = r_regs[w_rs1];
`ifdef DECODE_BYPASS_EN
        if (w_wr_en && w_rs1 == RdW) w_rd1 = ResultW;
`endif
    end

    always_comb begin
        w_rd2 = '0;
        if (w_a2 != 5'd0 && w_a2 < 5'd19) w_rd2 = r_regs[w_a2];
`ifdef DECODE_BYPASS_EN
        if (w_wr_en && w_a2 == RdW) w_rd2 = ResultW;
`endif
    end

    always_comb begin
        w_regwrite  = 1'b0;
        w_memwrite  = 1'b0;
        w_jump      = 1'b0;
        w_branch    = 1'b0;
        w_alusrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_aluctrl   = 3'b000;
        case (w_type)
            T_RALU: begin
                w_regwrite = 1'b1;
                w_aluctrl  = w_funct;
            end
            T_IALU: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                if (w_funct == 3'b111) w_resultsrc = 2'b01;
                else                   w_aluctrl   = w_funct;
            end
            T_MEM: begin
                if (w_funct == 3'b000) begin
                    w_memwrite = 1'b1;
                    w_alusrc   = 1'b1;
                end else if (w_funct == 3'b001) begin
                    w_branch  = 1'b1;
                    w_aluctrl = 3'b001;
                end
            end
            T_JAL: begin
                w_jump      = 1'b1;
                w_regwrite  = 1'b1;
                w_resultsrc = 2'b10;
            end
            default: ;
        endcase
    end

    assign w_imm = (w_type == T_JAL) ? {{9{InstrD[19]}}, InstrD[19:10]}
                                     : {{14{InstrD[19]}}, InstrD[19:15]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            RDE         <= '0;
        end else begin
            RegWriteE   <= w_regwrite;
            MemWriteE   <= w_memwrite;
            JumpE       <= w_jump;
            BranchE     <= w_branch;
            ALUSrcE     <= w_alusrc;
            ResultSrcE  <= w_resultsrc;
            ALUControlE <= w_aluctrl;
            RD1E        <= w_rd1;
            RD2E        <= w_rd2;
            ImmExtE     <= w_imm;
            PCE         <= PCD;
            RDE         <= w_rd;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode; expectations follow DECODE_BYPASS_EN when it is defined.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic [19:0] InstrD;
    logic [18:0] ResultW;
    logic [14:0] PCD;
    logic [4:0]  RdW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [18:0] RD1E, RD2E, ImmExtE;
    logic [14:0] PCE;
    logic [4:0]  RDE;

    int checks = 0;
    int errors = 0;

`ifdef DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    decode dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .InstrD(InstrD),
        .ResultW(ResultW), .PCD(PCD), .RdW(RdW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .RDE(RDE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {RegWrite,MemWrite,Jump,Branch,ALUSrc,ResultSrc,ALUControl}
    function automatic logic [9:0] ctl();
        return {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
    endfunction

    function automatic logic [101:0] all_out();
        return {ctl(), RD1E, RD2E, ImmExtE, PCE, RDE};
    endfunction

    task automatic test_reset();
        reset = 1'b0; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 19'h9;
        InstrD = 20'h00429; PCD = 15'h7;
        tick(); tick();
        checks++;
        if (all_out() !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", all_out());
        end
        @(negedge clk);
        RegWriteW = 1'b0; InstrD = 20'h00C00; reset = 1'b1;  // rs1=3
        tick();
        checks++;
        if (RD1E !== 19'h0) begin
            errors++; $display("FAIL no_write_in_reset got %h want 0", RD1E);
        end
    endtask

    task automatic test_i_alu();
        InstrD = 20'h00429; PCD = 15'h5; RegWriteW = 1'b0;
        tick();
        checks++;
        if (ctl() !== 10'b1_0_0_0_1_00_001) begin
            errors++; $display("FAIL i_alu_ctl got %b want 1000100001", ctl());
        end
        checks++;
        if ({RD1E, ImmExtE, PCE, RDE} !== {19'h0, 19'h0, 15'h5, 5'd1}) begin
            errors++; $display("FAIL i_alu_data got %h/%h/%h/%h want 0/0/5/1", RD1E, ImmExtE, PCE, RDE);
        end
    endtask

    task automatic test_write_read();
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 19'h5; InstrD = 20'h01440;
        tick();
        RegWriteW = 1'b0;
        checks++;
        if (RD1E !== (BYP ? 19'h5 : 19'h0)) begin
            errors++; $display("FAIL rd1_same_cycle got %h want %h", RD1E, BYP ? 19'h5 : 19'h0);
        end
        checks++;
        if (RDE !== 5'd2 || ctl() !== 10'b1_0_0_0_0_00_000) begin
            errors++; $display("FAIL r_alu_ctl got rd=%0d ctl=%b want rd=2 ctl=1000000000", RDE, ctl());
        end
        tick();
        checks++;
        if (RD1E !== 19'h5) begin
            errors++; $display("FAIL rd1_next_cycle got %h want 5", RD1E);
        end
        InstrD = 20'h28005;  // R-type funct 101, rs2=5
        tick();
        checks++;
        if ({RD2E, ImmExtE, ALUControlE, ALUSrcE} !== {19'h5, 19'h5, 3'b101, 1'b0}) begin
            errors++; $display("FAIL rd2_rs2 got %h/%h/%b/%b want 5/5/101/0", RD2E, ImmExtE, ALUControlE, ALUSrcE);
        end
        InstrD = 20'h000B0;  // store, port 2 reads rd=5
        tick();
        checks++;
        if ({RD2E, RD1E, MemWriteE, RegWriteE, ALUSrcE} !== {19'h5, 19'h0, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rd2_rd_store got %h/%h/%b%b%b want 5/0/101", RD2E, RD1E, MemWriteE, RegWriteE, ALUSrcE);
        end
    endtask

    task automatic test_boundaries();
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 19'h7; InstrD = 20'h00000;
        tick();
        RdW = 5'd20;
        tick();
        RdW = 5'd18; ResultW = 19'h12345;
        tick();
        RegWriteW = 1'b0;
        tick();
        checks++;
        if (RD1E !== 19'h0) begin
            errors++; $display("FAIL r0_read got %h want 0", RD1E);
        end
        InstrD = 20'h05000;  // rs1=20
        tick();
        checks++;
        if (RD1E !== 19'h0) begin
            errors++; $display("FAIL oob20_read got %h want 0", RD1E);
        end
        InstrD = 20'h01400;  // rs1=5 unchanged
        tick();
        checks++;
        if (RD1E !== 19'h5) begin
            errors++; $display("FAIL r5_kept got %h want 5", RD1E);
        end
        InstrD = 20'h04800;  // rs1=18
        tick();
        checks++;
        if (RD1E !== 19'h12345) begin
            errors++; $display("FAIL r18_read got %h want 12345", RD1E);
        end
        InstrD = 20'h04C00;  // rs1=19
        tick();
        checks++;
        if (RD1E !== 19'h0) begin
            errors++; $display("FAIL oob19_read got %h want 0", RD1E);
        end
    endtask

    task automatic test_imm_jump();
        InstrD = 20'hF8008;
        tick();
        checks++;
        if (ImmExtE !== 19'h7FFFF) begin
            errors++; $display("FAIL imm_ialu got %h want 7ffff", ImmExtE);
        end
        InstrD = 20'h80018;
        tick();
        checks++;
        if (ctl() !== 10'b1_0_1_0_0_10_000 || ImmExtE !== 19'h7FE00) begin
            errors++; $display("FAIL jal got ctl=%b imm=%h want 1010010000 7fe00", ctl(), ImmExtE);
        end
    endtask

    task automatic test_ctl_misc();
        InstrD = 20'h00011;
        tick();
        checks++;
        if (ctl() !== 10'b0_0_0_1_0_00_001) begin
            errors++; $display("FAIL branch got %b want 0001000001", ctl());
        end
        InstrD = 20'h0000F;  // load
        tick();
        checks++;
        if (ctl() !== 10'b1_0_0_0_1_01_000) begin
            errors++; $display("FAIL load got %b want 1000101000", ctl());
        end
        InstrD = 20'h00012;  // type 10 funct 010
        tick();
        checks++;
        if (ctl() !== 10'b0) begin
            errors++; $display("FAIL nop got %b want 0", ctl());
        end
    endtask

    task automatic test_midcycle_reset();
        InstrD = 20'h01429; PCD = 15'h3;
        tick();
        #3 reset = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++; $display("FAIL async_reset got %h want 0", all_out());
        end
        @(negedge clk);
        reset = 1'b1; InstrD = 20'h01400;
        tick();
        checks++;
        if (RD1E !== 19'h0) begin
            errors++; $display("FAIL rf_cleared got %h want 0", RD1E);
        end
    endtask

    initial begin
        test_reset();
        test_i_alu();
        test_write_read();
        test_boundaries();
        test_imm_jump();
        test_ctl_misc();
        test_midcycle_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
